// File: rtl/data_island_sequencer_if.sv
// data_island_sequencer_if
// Groups the upstream first-word-fall-through packet queue signals. The
// queue drives the head packet and fill level. The sequencer answers with
// packetPop, which consumes the head on the same clock edge.
//
// Signals:
//   packetsAvailable  packets currently held by the queue
//   packetValid       queue head valid
//   packetHeader      queue head header (24 bits)
//   packetSub0..3     queue head subpackets (56 bits each)
//   packetPop         consume the queue head this clock
//
// Modports:
//   master  queue side (drives the head, observes pop)
//   slave   sequencer side (observes the head, drives pop)
interface data_island_sequencer_if;
  logic [4:0]  packetsAvailable;
  logic        packetValid;
  logic [23:0] packetHeader;
  logic [55:0] packetSub0;
  logic [55:0] packetSub1;
  logic [55:0] packetSub2;
  logic [55:0] packetSub3;
  logic        packetPop;

  modport master (
    output packetsAvailable, packetValid, packetHeader,
    output packetSub0, packetSub1, packetSub2, packetSub3,
    input  packetPop
  );

  modport slave (
    input  packetsAvailable, packetValid, packetHeader,
    input  packetSub0, packetSub1, packetSub2, packetSub3,
    output packetPop
  );
endinterface

// File: rtl/data_island_sequencer.sv
// data_island_sequencer
// Schedules one HDMI data island inside blanking. The island has the
// following parts, in order: leading control, preamble, leading guard band,
// N back-to-back 32-clock packets, and a trailing guard band. Packets are
// popped from the upstream queue and held, registered, for the TERC4
// serializer for the whole of their 32 clocks.
//
// Ports:
//   clock, reset        pixel clock, asynchronous active-high reset
//   islandStart         one-clock request to begin an island
//   blankingClocks      blanking clocks left, counted from the islandStart clock
//   queue               upstream packet queue (data_island_sequencer_if.slave)
//   mode                00 control, 01 preamble, 10 guard band, 11 packet
//   isFirstPacketClock  first clock of each 32-clock packet
//   header, subpacket0..3  registered packet to the serializer
//   busy                island in progress
//   underflow           sticky null-fill flag (only with DATA_ISLAND_NULL_FILL_EN)
//
// Build option DATA_ISLAND_NULL_FILL_EN:
//   If the queue runs dry, the island keeps its length and the missing
//   slots are filled with all-zero packets.
//   Without this option, the island ends early.
module data_island_sequencer #(
  parameter int MAX_PACKETS  = 18,
  parameter int LEAD_CTRL    = 4,
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2,
  parameter int TRAIL_CTRL   = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        islandStart,
  input  logic [11:0] blankingClocks,
  data_island_sequencer_if.slave queue,
  output logic [1:0]  mode,
  output logic        isFirstPacketClock,
  output logic [23:0] header,
  output logic [55:0] subpacket0,
  output logic [55:0] subpacket1,
  output logic [55:0] subpacket2,
  output logic [55:0] subpacket3,
  output logic        busy
`ifdef DATA_ISLAND_NULL_FILL_EN
  ,
  output logic        underflow
`endif
);

  localparam logic [11:0] OVERHEAD =
    12'(LEAD_CTRL + PREAMBLE_LEN + 2 * GUARD_LEN + TRAIL_CTRL);
  localparam logic [11:0] MAX_N      = 12'(MAX_PACKETS);
  localparam logic [4:0]  LEAD_LAST  = 5'(LEAD_CTRL - 1);
  localparam logic [4:0]  PRE_LAST   = 5'(PREAMBLE_LEN - 1);
  localparam logic [4:0]  GUARD_LAST = 5'(GUARD_LEN - 1);
  localparam logic [4:0]  PHASE_LAST = 5'd31;

`ifdef DATA_ISLAND_NULL_FILL_EN
  localparam bit NULL_FILL = 1'b1;
`else
  localparam bit NULL_FILL = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, LEAD, PREAMBLE, LGUARD, PACKET, TGUARD
  } state_t;

  state_t      state, nextState;
  logic [4:0]  phase, nextPhase;
  logic [4:0]  packetCount, nextPacketCount;
  logic [4:0]  numPackets;
  logic [11:0] fit, availWide, nCalc;
  logic        accept, loadSlot, lastPacket;

  // Work out how many whole packets fit in the remaining blanking after
  // the fixed overhead. Clamp that to the queue fill level and to the HDMI
  // packet limit. An island is only started when at least one packet fits.
  always_comb begin
    fit = '0;
    if (blankingClocks >= OVERHEAD)
      fit = (blankingClocks - OVERHEAD) >> 5;
    availWide = {7'd0, queue.packetsAvailable};
    nCalc = availWide;
    if (fit < nCalc)
      nCalc = fit;
    if (MAX_N < nCalc)
      nCalc = MAX_N;
  end

  assign accept     = islandStart && (state == IDLE) && (nCalc != 12'd0);
  assign lastPacket = (packetCount == numPackets - 5'd1);

  // Next-state and output decode. The phase counter times every state.
  // It restarts at zero on each state change and wraps 31->0 between
  // back-to-back packets. A load slot is a clock on which the next packet
  // must be taken from the queue, ready for the following edge.
  always_comb begin
    nextState          = state;
    nextPhase          = phase + 5'd1;
    nextPacketCount    = packetCount;
    loadSlot           = 1'b0;
    mode               = 2'b00;
    busy               = 1'b1;
    isFirstPacketClock = 1'b0;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        nextPhase = '0;
        if (accept)
          nextState = LEAD;
      end
      LEAD: begin
        if (phase == LEAD_LAST) begin
          nextState = PREAMBLE;
          nextPhase = '0;
        end
      end
      PREAMBLE: begin
        mode = 2'b01;
        if (phase == PRE_LAST) begin
          nextState = LGUARD;
          nextPhase = '0;
        end
      end
      LGUARD: begin
        mode = 2'b10;
        if (phase == GUARD_LAST) begin
          loadSlot        = 1'b1;
          nextPhase       = '0;
          nextPacketCount = '0;
          nextState       = (queue.packetValid || NULL_FILL) ? PACKET : TGUARD;
        end
      end
      PACKET: begin
        mode               = 2'b11;
        isFirstPacketClock = (phase == 5'd0);
        if (phase == PHASE_LAST) begin
          if (lastPacket) begin
            nextState = TGUARD;
            nextPhase = '0;
          end else begin
            loadSlot = 1'b1;
            if (queue.packetValid || NULL_FILL)
              nextPacketCount = packetCount + 5'd1;
            else begin
              nextState = TGUARD;
              nextPhase = '0;
            end
          end
        end
      end
      TGUARD: begin
        mode = 2'b10;
        if (phase == GUARD_LAST) begin
          nextState = IDLE;
          nextPhase = '0;
        end
      end
      default: begin
        nextState = IDLE;
        nextPhase = '0;
        busy      = 1'b0;
      end
    endcase
  end

  assign queue.packetPop = loadSlot && queue.packetValid;

  // State, counters and the packet holding registers. A packet is loaded
  // only on a load slot and then held for its full 32 clocks. With null
  // fill, an empty queue on a load slot loads zeros and flags underflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      phase       <= '0;
      packetCount <= '0;
      numPackets  <= '0;
      header      <= '0;
      subpacket0  <= '0;
      subpacket1  <= '0;
      subpacket2  <= '0;
      subpacket3  <= '0;
`ifdef DATA_ISLAND_NULL_FILL_EN
      underflow   <= 1'b0;
`endif
    end else begin
      state       <= nextState;
      phase       <= nextPhase;
      packetCount <= nextPacketCount;
      if (accept) begin
        numPackets <= nCalc[4:0];
`ifdef DATA_ISLAND_NULL_FILL_EN
        underflow  <= 1'b0;
`endif
      end
      if (loadSlot) begin
        if (queue.packetValid) begin
          header     <= queue.packetHeader;
          subpacket0 <= queue.packetSub0;
          subpacket1 <= queue.packetSub1;
          subpacket2 <= queue.packetSub2;
          subpacket3 <= queue.packetSub3;
        end
`ifdef DATA_ISLAND_NULL_FILL_EN
        else begin
          header     <= '0;
          subpacket0 <= '0;
          subpacket1 <= '0;
          subpacket2 <= '0;
          subpacket3 <= '0;
          underflow  <= 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_data_island_sequencer.sv
// tb_data_island_sequencer
// Directed bench for data_island_sequencer. A small queue model feeds
// numbered packets. Each island is checked clock by clock against
// hand-derived timing: 4 lead clocks, 8 preamble clocks, 2 guard clocks,
// 32 clocks per packet and 2 trailing guard clocks.
module tb_data_island_sequencer;
  logic        clock = 1'b0;
  logic        reset;
  logic        islandStart;
  logic [11:0] blankingClocks;
  logic [1:0]  mode;
  logic        isFirstPacketClock;
  logic [23:0] header;
  logic [55:0] subpacket0, subpacket1, subpacket2, subpacket3;
  logic        busy;
`ifdef DATA_ISLAND_NULL_FILL_EN
  logic        underflow;
  localparam bit nullFill = 1'b1;
`else
  localparam bit nullFill = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  int headIdx;
  int validCount;

  data_island_sequencer_if qIf ();

  data_island_sequencer dut (
    .clock(clock),
    .reset(reset),
    .islandStart(islandStart),
    .blankingClocks(blankingClocks),
    .queue(qIf),
    .mode(mode),
    .isFirstPacketClock(isFirstPacketClock),
    .header(header),
    .subpacket0(subpacket0),
    .subpacket1(subpacket1),
    .subpacket2(subpacket2),
    .subpacket3(subpacket3),
    .busy(busy)
`ifdef DATA_ISLAND_NULL_FILL_EN
    ,
    .underflow(underflow)
`endif
  );

  // 10-time-unit pixel clock.
  always #5 clock = ~clock;

  function automatic logic [23:0] patHeader(input int j);
    return {8'hA5, 8'(j), 8'h3C};
  endfunction

  function automatic logic [55:0] patSub(input int i, input int j);
    return {8'(i + 1), 40'hDEADBEEF00, 8'(j)};
  endfunction

  // Present queue entry headIdx. An empty queue shows all-ones garbage,
  // so a null-filled slot cannot be mistaken for data read off the bus.
  task automatic setHead();
    if (headIdx < validCount) begin
      qIf.packetValid  = 1'b1;
      qIf.packetHeader = patHeader(headIdx);
      qIf.packetSub0   = patSub(0, headIdx);
      qIf.packetSub1   = patSub(1, headIdx);
      qIf.packetSub2   = patSub(2, headIdx);
      qIf.packetSub3   = patSub(3, headIdx);
    end else begin
      qIf.packetValid  = 1'b0;
      qIf.packetHeader = '1;
      qIf.packetSub0   = '1;
      qIf.packetSub1   = '1;
      qIf.packetSub2   = '1;
      qIf.packetSub3   = '1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Run one island, pulsing islandStart in the clock before the first
  // sampled clock (t0). expN is the hand-computed packet count and
  // validPkts is how many packets the queue really holds. If midStart is
  // set, islandStart is pulsed again during the PACKET state.
  task automatic applyStimulus(input logic [11:0] blank, input logic [4:0] avail,
                               input int validPkts, input int expN,
                               input bit midStart);
    int expP, expPops, endPkt, lastBusy, j;
    int modeErr, busyErr, popErr, firstErr, pops, firsts;
    logic [1:0] expMode;
    logic expPop, expFirst, popNow;
    expP     = nullFill ? expN : ((validPkts < expN) ? validPkts : expN);
    expPops  = (validPkts < expP) ? validPkts : expP;
    endPkt   = 14 + 32 * expP;
    lastBusy = endPkt + 2;
    modeErr = 0; busyErr = 0; popErr = 0; firstErr = 0; pops = 0; firsts = 0;
    headIdx    = 0;
    validCount = validPkts;
    setHead();
    qIf.packetsAvailable = avail;
    blankingClocks = blank;
    islandStart = 1'b1;
    @(posedge clock);
    #1 islandStart = 1'b0;
    @(negedge clock);
    for (int k = 1; k <= lastBusy + 2; k++) begin
      expMode = (k <= 4) ? 2'b00 : (k <= 12) ? 2'b01 : (k <= 14) ? 2'b10 :
                (k <= endPkt) ? 2'b11 : (k <= lastBusy) ? 2'b10 : 2'b00;
      expFirst = (k >= 15) && (k <= endPkt) && ((k - 15) % 32 == 0);
      expPop   = ((k == 14) || ((k > 14) && (k < endPkt) && ((k - 14) % 32 == 0)))
                 && (((k - 14) / 32) < validPkts);
      if (mode !== expMode) modeErr++;
      if (busy !== (k <= lastBusy)) busyErr++;
      if (qIf.packetPop !== expPop) popErr++;
      if (isFirstPacketClock !== expFirst) firstErr++;
      if (qIf.packetPop === 1'b1) pops++;
      if (isFirstPacketClock === 1'b1) firsts++;
      if ((k >= 15) && (k <= endPkt) && ((k - 15) % 32 == 5)) begin
        j = (k - 15) / 32;
        checkOutput($sformatf("hdr%0d", j), header,
                    (j < validPkts) ? patHeader(j) : 24'd0);
        checkOutput($sformatf("sub3_%0d", j), subpacket3,
                    (j < validPkts) ? patSub(3, j) : 56'd0);
      end
      popNow = qIf.packetPop;
      @(posedge clock);
      #1;
      if (popNow) begin
        headIdx++;
        setHead();
      end
      islandStart = midStart && (k == 40);
      @(negedge clock);
    end
    islandStart = 1'b0;
    checkOutput("modeTrace", modeErr, 0);
    checkOutput("busyTrace", busyErr, 0);
    checkOutput("popTrace", popErr, 0);
    checkOutput("firstTrace", firstErr, 0);
    checkOutput("popCount", pops, expPops);
    checkOutput("firstCount", firsts, expP);
`ifdef DATA_ISLAND_NULL_FILL_EN
    checkOutput("underflow", underflow, (validPkts < expN) ? 1 : 0);
`endif
  endtask

  // islandStart with too little blanking must do nothing at all.
  task automatic checkIgnored(input logic [11:0] blank, input logic [4:0] avail);
    int busySeen, popSeen;
    busySeen = 0; popSeen = 0;
    headIdx = 0; validCount = 5; setHead();
    qIf.packetsAvailable = avail;
    blankingClocks = blank;
    islandStart = 1'b1;
    @(negedge clock);
    islandStart = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (busy === 1'b1) busySeen++;
      if (qIf.packetPop === 1'b1) popSeen++;
      @(negedge clock);
    end
    checkOutput("ignoreBusy", busySeen, 0);
    checkOutput("ignorePop", popSeen, 0);
  endtask

  // Start a 2-packet island and assert reset at phase 10 of packet 0.
  // The clear is asynchronous, so it must show before the next clock edge.
  task automatic resetMidIsland();
    headIdx = 0; validCount = 2; setHead();
    qIf.packetsAvailable = 5'd2;
    blankingClocks = 12'd138;
    islandStart = 1'b1;
    @(posedge clock);
    #1 islandStart = 1'b0;
    @(negedge clock);
    for (int k = 1; k < 25; k++) begin
      if (k == 20) checkOutput("preResetHdr", header, patHeader(0));
      if (qIf.packetPop === 1'b1) begin
        @(posedge clock);
        #1 headIdx++; setHead();
      end
      @(negedge clock);
    end
    reset = 1'b1;
    #1;
    checkOutput("rstMidMode", mode, 2'b00);
    checkOutput("rstMidBusy", busy, 1'b0);
    checkOutput("rstMidHdr", header, 24'd0);
    checkOutput("rstMidSub0", subpacket0, 56'd0);
    checkOutput("rstMidPop", qIf.packetPop, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("postRstBusy", busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    islandStart = 1'b0;
    blankingClocks = '0;
    headIdx = 0; validCount = 0; setHead();
    qIf.packetsAvailable = '0;
    repeat (3) @(negedge clock);
    checkOutput("rstMode", mode, 2'b00);
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstPop", qIf.packetPop, 1'b0);
    checkOutput("rstFirst", isFirstPacketClock, 1'b0);
    checkOutput("rstHdr", header, 24'd0);
    checkOutput("rstSub2", subpacket2, 56'd0);
    reset = 1'b0;
    @(negedge clock);

    $display("[TB] two-packet island");
    applyStimulus(12'd138, 5'd2, 2, 2, 1'b0);
    $display("[TB] too little blanking, then single packet");
    checkIgnored(12'd59, 5'd5);
    applyStimulus(12'd60, 5'd5, 5, 1, 1'b0);
    $display("[TB] packet count clamp");
    applyStimulus(12'd4095, 5'd31, 31, 18, 1'b0);
    $display("[TB] queue underflow");
    applyStimulus(12'd138, 5'd3, 1, 3, 1'b0);
    $display("[TB] islandStart while busy");
    applyStimulus(12'd138, 5'd2, 2, 2, 1'b1);
    $display("[TB] reset mid-island");
    resetMidIsland();
    applyStimulus(12'd138, 5'd2, 2, 2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_island_sequencer.md
Name: data_island_sequencer

Overview:
- Schedules one HDMI data island period inside horizontal/vertical blanking.
- Sequence: leading control, preamble, leading guard band, N back-to-back 32-clock packets, trailing guard band.
- Pops packets from an upstream first-word-fall-through packet queue and presents them, registered, to the downstream TERC4 packet serializer.
- Drives that serializer's isFirstPacketClock strobe and a period-mode code for the TMDS channel mux.

Parameters:
MAX_PACKETS, 18, upper bound on packets per island (HDMI limit)
LEAD_CTRL, 4, control clocks between islandStart acceptance and preamble
PREAMBLE_LEN, 8, data island preamble clocks
GUARD_LEN, 2, guard band clocks (leading and trailing each)
TRAIL_CTRL, 12, control clocks reserved after trailing guard in the fit calculation

Ports:
clock  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
islandStart  in  1  one-clock request to begin an island
blankingClocks  in  12  blanking clocks remaining, counted from the islandStart clock
packetsAvailable  in  5  packets currently held by the upstream queue
packetValid  in  1  queue head valid
packetHeader  in  24  queue head header
packetSub0..packetSub3  in  56 each  queue head subpackets
packetPop  out  1  consume queue head this clock
mode  out  2  00 control, 01 preamble, 10 data guard band, 11 data packet
isFirstPacketClock  out  1  first clock of each 32-clock packet
header  out  24  registered packet header to serializer
subpacket0..subpacket3  out  56 each  registered subpackets to serializer
busy  out  1  island in progress

Behaviour:
- Reset values (async on reset high): state IDLE; mode=00; busy, packetPop, isFirstPacketClock=0; header and subpackets all zero; counters zero.
- OVERHEAD = LEAD_CTRL+PREAMBLE_LEN+2*GUARD_LEN+TRAIL_CTRL, 28 at defaults.
- fit = 0 if blankingClocks<OVERHEAD, else (blankingClocks-OVERHEAD)>>5.
- N = min(packetsAvailable, fit, MAX_PACKETS), computed in 12-bit unsigned arithmetic and latched on acceptance.
- islandStart is accepted only in IDLE with N>0. Otherwise it is ignored: no state change, no pop. This covers islandStart while busy.
- States, timing relative to the acceptance clock t0:
  - LEAD: t0+1..t0+4, mode=00, busy=1.
  - PREAMBLE: t0+5..t0+12, mode=01.
  - LGUARD: t0+13..t0+14, mode=10.
  - PACKET: 32*N clocks from t0+15, mode=11.
  - TGUARD: 2 clocks, mode=10.
  - IDLE: busy=0, mode=00.
- Phase counter: 5-bit, wraps 31->0 per packet. Packet counter: 5-bit, counts up to N-1.
- isFirstPacketClock=1 exactly on phase 0 of each packet (t0+15+32k).
- Pop/load clocks: last LGUARD clock for packet 0, and phase 31 of packet k for packet k+1 (k<N-1).
  - On a pop/load clock with packetValid=1: packetPop=1; header/subpackets load from the queue head at that edge.
  - Outputs then hold stable for the full 32 clocks of their packet.
- No pop on phase 31 of the final packet; move to TGUARD.
- Underflow (packetValid=0 on a pop/load clock), without the optional feature:
  - packetPop=0.
  - At the last LGUARD clock: go directly to TGUARD, no packets.
  - At phase 31: end after the current packet; TGUARD follows.
- Reset mid-island: immediate return to IDLE with reset values; no further pops; no guard band emitted.
- Inputs other than islandStart/packetValid are sampled only at acceptance and pop clocks.

Optional Feature:
DATA_ISLAND_NULL_FILL_EN:
- Defined:
  - Adds output underflow (1 bit, sticky, cleared by reset or by the next accepted islandStart).
  - On underflow the island keeps its full N packets; the missing packet is replaced with a null packet (header and all subpackets zero).
  - packetPop=0 for that slot; underflow set.
- Undefined: early termination as in Behaviour; no underflow port.

Test Plan:
- blankingClocks=138, packetsAvailable=2, queue valid, islandStart at t0 -> N=2; mode=01 t0+5..t0+12; mode=10 t0+13..14; packetPop at t0+14 and t0+46; isFirstPacketClock at t0+15 and t0+47; mode=10 t0+79..t0+80; busy=0 from t0+81.
- blankingClocks=59, packetsAvailable=5 -> fit=0, islandStart ignored, busy stays 0; blankingClocks=60 -> N=1, single packet.
- packetsAvailable=31, blankingClocks=4095 -> N clamps to 18; exactly 18 pops and 18 isFirstPacketClock pulses.
- N=3, packetValid drops before second pop clock -> one packet then TGUARD; with DATA_ISLAND_NULL_FILL_EN: three packets, second all-zero, underflow=1.
- reset asserted at phase 10 of packet 0 -> mode=00, busy=0, header zero in same cycle (async); next islandStart accepted normally.
- islandStart pulsed during PACKET state -> ignored; island timing and pop count unchanged.
